spi_ctrl: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_ctrl_if.sv | 33 +++
 rtl/spi_stop_detect.sv | 26 ++
 rtl/spi_ctrl.sv | 127 ++++++++++++
 tb/tb_spi_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the PSEC5 serial configuration slave.
// Address map: 1..3 are special registers, 4..59 select counter serializers.
package spi_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ADDR_TCM       = 8'd1;
    localparam byte_t ADDR_INST      = 8'd2;
    localparam byte_t ADDR_MODE      = 8'd3;
    localparam byte_t FIRST_CNT_ADDR = 8'd4;
    localparam byte_t LAST_CNT_ADDR  = 8'd59;
    localparam byte_t REGS_PER_CNT   = 8'd7;
    localparam int    NUM_CNT        = 8;
    localparam int    STOP_CNT       = 8;

endpackage

// File: rtl/spi_ctrl_if.sv
// Serial data and register/decode outputs of the spi_ctrl slave.
// The slave modport is the design side; master is the driving/observing side.
interface spi_ctrl_if;

    logic                             serial_in;
    logic                             serial_out;
    logic [spi_pkg::NUM_CNT-1:0]      load_cnt_ser;
    logic [2:0]                       select_reg;
    spi_pkg::byte_t                   trigger_channel_mask;
    spi_pkg::byte_t                   instruction;
    spi_pkg::byte_t                   mode;

    modport slave (
        input  serial_in,
        output serial_out,
        output load_cnt_ser,
        output select_reg,
        output trigger_channel_mask,
        output instruction,
        output mode
    );

    modport master (
        output serial_in,
        input  serial_out,
        input  load_cnt_ser,
        input  select_reg,
        input  trigger_channel_mask,
        input  instruction,
        input  mode
    );

endinterface

// File: rtl/spi_stop_detect.sv
// sclk stop watchdog: counts iclk pulses while sclk is idle low and pulls
// sclk_stop_rstn low during the STOP_CNT-th pulse so a stalled message restarts.
module spi_stop_detect import spi_pkg::*; (
    input  logic sclk,
    input  logic rstn,
    input  logic iclk,
    output logic sclk_stop_rstn
);

    logic [3:0] count;
    logic       clr;

    assign clr = sclk | ~rstn;

    // Count iclk falling edges, saturating; any sclk activity or reset clears it
    always_ff @(negedge iclk or posedge clr) begin
        if (clr) begin
            count <= 4'd0;
        end else if (count != 4'(STOP_CNT)) begin
            count <= count + 4'd1;
        end
    end

    assign sclk_stop_rstn = ~((count == 4'(STOP_CNT - 1)) & iclk);

endmodule

// File: rtl/spi_ctrl.sv
// PSEC5 serial configuration/readout slave. First byte of a message is the
// address, later bytes write/read the current address which then increments.
// Optional readback path is built when SPI_READBACK_EN is defined; otherwise
// serial_out is tied low.
module spi_ctrl import spi_pkg::*; (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       iclk,
    spi_ctrl_if.slave  bus
);

    logic       sclk_stop_rstn;
    logic       proto_rstn;
    byte_t      address;
    logic [2:0] bit_cnt;
    logic       msgi;
    logic [6:0] rx;
    byte_t      rx_byte;
    logic       byte_done;
    byte_t      tcm_q;
    byte_t      inst_q;
    byte_t      mode_q;

    spi_stop_detect u_stop (
        .sclk           (sclk),
        .rstn           (rstn),
        .iclk           (iclk),
        .sclk_stop_rstn (sclk_stop_rstn)
    );

    assign proto_rstn = rstn & sclk_stop_rstn;
    assign rx_byte    = {rx, bus.serial_in};
    assign byte_done  = (bit_cnt == 3'd7);

    // Byte assembly and message sequencing; the watchdog also restarts these
    always_ff @(posedge sclk or negedge proto_rstn) begin
        if (!proto_rstn) begin
            rx      <= 7'd0;
            bit_cnt <= 3'd0;
            msgi    <= 1'b0;
            address <= 8'd0;
        end else begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
                if (!msgi) begin
                    address <= rx_byte;
                    msgi    <= 1'b1;
                end else begin
                    address <= address + 8'd1;
                end
            end
        end
    end

    // Configuration registers survive a watchdog restart, only rstn clears them
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            tcm_q  <= 8'd0;
            inst_q <= 8'd0;
            mode_q <= 8'd0;
        end else if (byte_done && msgi) begin
            case (address)
                ADDR_TCM:  tcm_q  <= rx_byte;
                ADDR_INST: inst_q <= rx_byte;
                ADDR_MODE: mode_q <= rx_byte;
                default:   ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    byte_t snap_addr;
    byte_t snap_next;
    byte_t snapshot;
    logic  serial_out_q;

    // Select which register value the next byte will shift out
    always_comb begin
        snap_addr = msgi ? (address + 8'd1) : rx_byte;
        snap_next = 8'd0;
        case (snap_addr)
            ADDR_TCM:  snap_next = tcm_q;
            ADDR_INST: snap_next = inst_q;
            ADDR_MODE: snap_next = mode_q;
            default:   snap_next = 8'd0;
        endcase
    end

    // Shift the captured snapshot out MSB first, recapturing at each byte end
    always_ff @(posedge sclk or negedge proto_rstn) begin
        if (!proto_rstn) begin
            snapshot     <= 8'd0;
            serial_out_q <= 1'b0;
        end else begin
            serial_out_q <= snapshot[3'd7 - bit_cnt];
            if (byte_done) begin
                snapshot <= snap_next;
            end
        end
    end

    assign bus.serial_out = serial_out_q;
`else
    assign bus.serial_out = 1'b0;
`endif

    // Map counter-readout addresses onto one-hot serializer select and index
    always_comb begin
        bus.load_cnt_ser = '0;
        bus.select_reg   = 3'd0;
        if (address >= FIRST_CNT_ADDR && address <= LAST_CNT_ADDR) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (address >= FIRST_CNT_ADDR + 8'(i) * REGS_PER_CNT &&
                    address <  FIRST_CNT_ADDR + 8'(i + 1) * REGS_PER_CNT) begin
                    bus.load_cnt_ser[i] = 1'b1;
                    bus.select_reg = 3'(address - FIRST_CNT_ADDR - 8'(i) * REGS_PER_CNT);
                end
            end
        end
    end

    assign bus.trigger_channel_mask = tcm_q;
    assign bus.instruction          = inst_q;
    assign bus.mode                 = mode_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// Self-checking bench for spi_ctrl with a message-level reference model.
module tb_spi_ctrl;

    logic sclk;
    logic rstn;
    logic iclk;

    int total;
    int bad;

    logic [7:0] m_tcm;
    logic [7:0] m_inst;
    logic [7:0] m_mode;
    logic [7:0] m_addr;
    bit         m_msgi;

    spi_ctrl_if bus ();

    spi_ctrl dut (
        .sclk (sclk),
        .rstn (rstn),
        .iclk (iclk),
        .bus  (bus.slave)
    );

    function automatic logic [7:0] m_reg(input logic [7:0] a);
        case (a)
            8'd1:    return m_tcm;
            8'd2:    return m_inst;
            8'd3:    return m_mode;
            default: return 8'h00;
        endcase
    endfunction

    // Send one byte MSB first; returns the byte seen on serial_out and the model's expectation
    task automatic send_byte(input logic [7:0] b, output logic [7:0] rd, output logic [7:0] exp_rd);
        logic [7:0] r;
`ifdef SPI_READBACK_EN
        exp_rd = m_msgi ? m_reg(m_addr) : 8'h00;
`else
        exp_rd = 8'h00;
`endif
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bus.serial_in = b[i];
            #5 sclk = 1'b1;
            #1 r[i] = bus.serial_out;
            #4 sclk = 1'b0;
            #5;
        end
        rd = r;
        if (!m_msgi) begin
            m_addr = b;
            m_msgi = 1'b1;
        end else begin
            case (m_addr)
                8'd1:    m_tcm  = b;
                8'd2:    m_inst = b;
                8'd3:    m_mode = b;
                default: ;
            endcase
            m_addr = m_addr + 8'd1;
        end
    endtask

    task automatic send_bits(input int n, input logic [7:0] b);
        for (int i = 7; i > 7 - n; i--) begin
            bus.serial_in = b[i];
            #5 sclk = 1'b1;
            #5 sclk = 1'b0;
            #5;
        end
    endtask

    task automatic iclk_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            iclk = 1'b1;
            #5 iclk = 1'b0;
            #5;
        end
        if (n >= 8) m_msgi = 1'b0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #10;
        m_tcm = 0; m_inst = 0; m_mode = 0; m_addr = 0; m_msgi = 0;
        rstn = 1'b1;
        #10;
    endtask

    task automatic test_reset();
        pulse_reset();
        total += 6;
        if (bus.trigger_channel_mask !== 8'h00) begin bad++; $display("[TB] FAIL reset_tcm: got %h want 00", bus.trigger_channel_mask); end
        if (bus.instruction !== 8'h00) begin bad++; $display("[TB] FAIL reset_inst: got %h want 00", bus.instruction); end
        if (bus.mode !== 8'h00) begin bad++; $display("[TB] FAIL reset_mode: got %h want 00", bus.mode); end
        if (bus.load_cnt_ser !== 8'h00) begin bad++; $display("[TB] FAIL reset_load: got %h want 00", bus.load_cnt_ser); end
        if (bus.select_reg !== 3'd0) begin bad++; $display("[TB] FAIL reset_sel: got %0d want 0", bus.select_reg); end
        if (bus.serial_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_sout: got %b want 0", bus.serial_out); end
    endtask

    task automatic test_write();
        logic [7:0] rd, ex;
        logic [7:0] seq [4] = '{8'h01, 8'h29, 8'h06, 8'h04};
        foreach (seq[i]) begin
            send_byte(seq[i], rd, ex);
            total++;
            if (rd !== ex) begin bad++; $display("[TB] FAIL write_read%0d: got %h want %h", i, rd, ex); end
        end
        total += 3;
        if (bus.trigger_channel_mask !== 8'h29) begin bad++; $display("[TB] FAIL write_tcm: got %h want 29", bus.trigger_channel_mask); end
        if (bus.instruction !== 8'h06) begin bad++; $display("[TB] FAIL write_inst: got %h want 06", bus.instruction); end
        if (bus.mode !== 8'h04) begin bad++; $display("[TB] FAIL write_mode: got %h want 04", bus.mode); end
    endtask

    task automatic test_counter_decode();
        logic [7:0] rd, ex;
        iclk_pulses(8);
        send_byte(8'h04, rd, ex);
        for (int a = 4; a <= 59; a++) begin
            total += 2;
            if (bus.select_reg !== 3'((a - 4) % 7)) begin
                bad++; $display("[TB] FAIL decode_sel a=%0d: got %0d want %0d", a, bus.select_reg, (a - 4) % 7);
            end
            if (bus.load_cnt_ser !== 8'(1 << ((a - 4) / 7))) begin
                bad++; $display("[TB] FAIL decode_load a=%0d: got %h want %h", a, bus.load_cnt_ser, 8'(1 << ((a - 4) / 7)));
            end
            send_byte(8'($urandom_range(0, 255)), rd, ex);
        end
        total += 2;
        if (bus.load_cnt_ser !== 8'h00) begin bad++; $display("[TB] FAIL decode_after59_load: got %h want 00", bus.load_cnt_ser); end
        if (bus.select_reg !== 3'd0) begin bad++; $display("[TB] FAIL decode_after59_sel: got %0d want 0", bus.select_reg); end
    endtask

    task automatic test_readback();
        logic [7:0] rd, ex;
        logic [7:0] want [3];
`ifdef SPI_READBACK_EN
        want = '{8'h29, 8'h06, 8'h04};
`else
        want = '{8'h00, 8'h00, 8'h00};
`endif
        iclk_pulses(8);
        send_byte(8'h01, rd, ex);
        total++;
        if (rd !== 8'h00) begin bad++; $display("[TB] FAIL readback_addr: got %h want 00", rd); end
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00, rd, ex);
            total++;
            if (rd !== want[i]) begin bad++; $display("[TB] FAIL readback_byte%0d: got %h want %h", i, rd, want[i]); end
        end
        total += 3;
        if (bus.trigger_channel_mask !== 8'h00) begin bad++; $display("[TB] FAIL readback_tcm: got %h want 00", bus.trigger_channel_mask); end
        if (bus.instruction !== 8'h00) begin bad++; $display("[TB] FAIL readback_inst: got %h want 00", bus.instruction); end
        if (bus.mode !== 8'h00) begin bad++; $display("[TB] FAIL readback_mode: got %h want 00", bus.mode); end
    endtask

    task automatic test_partial_restart();
        logic [7:0] rd, ex, x, y;
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        send_bits(5, 8'hB7);
        iclk_pulses(8);
        send_byte(8'h02, rd, ex);
        send_byte(x, rd, ex);
        total++;
        if (bus.instruction !== x) begin bad++; $display("[TB] FAIL partial_inst: got %h want %h", bus.instruction, x); end
        iclk_pulses(7);
        send_byte(y, rd, ex);
        total += 2;
        if (bus.mode !== y) begin bad++; $display("[TB] FAIL seven_pulse_mode: got %h want %h", bus.mode, y); end
        if (bus.instruction !== x) begin bad++; $display("[TB] FAIL seven_pulse_inst: got %h want %h", bus.instruction, x); end
    endtask

    task automatic test_random();
        logic [7:0] rd, ex, b, start;
        int n;
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0:       start = 8'($urandom_range(0, 5));
                1:       start = 8'($urandom_range(57, 62));
                default: start = 8'($urandom_range(250, 255));
            endcase
            n = $urandom_range(1, 8);
            iclk_pulses(8);
            send_byte(start, rd, ex);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                send_byte(b, rd, ex);
                total++;
                if (rd !== ex) begin bad++; $display("[TB] FAIL random_read it=%0d k=%0d: got %h want %h", it, k, rd, ex); end
            end
            total += 3;
            if (bus.trigger_channel_mask !== m_tcm) begin bad++; $display("[TB] FAIL random_tcm it=%0d: got %h want %h", it, bus.trigger_channel_mask, m_tcm); end
            if (bus.instruction !== m_inst) begin bad++; $display("[TB] FAIL random_inst it=%0d: got %h want %h", it, bus.instruction, m_inst); end
            if (bus.mode !== m_mode) begin bad++; $display("[TB] FAIL random_mode it=%0d: got %h want %h", it, bus.mode, m_mode); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        sclk = 1'b0;
        iclk = 1'b0;
        rstn = 1'b1;
        bus.serial_in = 1'b0;
        m_tcm = 0; m_inst = 0; m_mode = 0; m_addr = 0; m_msgi = 0;
        #1;
        test_reset();
        test_write();
        test_counter_decode();
        test_readback();
        test_partial_restart();
        test_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
